// File: rtl/bp_be_csr_access_arbiter.sv
// rtl/bp_be_csr_access_arbiter.sv - two-requester read-modify-write sequencer for the CSR file port
// Optional starvation guard for requester 1 when BP_BE_CSR_ARB_FAIR_EN is defined.

module bp_be_csr_access_arbiter #(
    parameter int addr_width_p = 12,
    parameter int data_width_p = 64
`ifdef BP_BE_CSR_ARB_FAIR_EN
    , parameter int starve_limit_p = 8
`endif
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_yumi_o,
    input  logic [1:0][1:0]               req_op_i,
    input  logic [1:0][addr_width_p-1:0]  req_addr_i,
    input  logic [1:0][data_width_p-1:0]  req_data_i,
    output logic                          resp_v_o,
    output logic                          resp_id_o,
    output logic [data_width_p-1:0]       resp_data_o,
    output logic                          resp_illegal_o,
    input  logic                          resp_ready_i,
    output logic                          csr_r_v_o,
    output logic                          csr_w_v_o,
    output logic [addr_width_p-1:0]       csr_addr_o,
    output logic [data_width_p-1:0]       csr_data_o,
    input  logic [data_width_p-1:0]       csr_data_i,
    input  logic                          csr_illegal_i
);

    typedef enum logic [2:0] {
        e_idle,
        e_read,
        e_capture,
        e_write,
        e_resp
    } state_e;

    state_e                    state_q;
    logic [1:0]                yumi_q;
    logic                      owner_q;
    logic [1:0]                op_q;
    logic [addr_width_p-1:0]   addr_q;
    logic [data_width_p-1:0]   data_q;
    logic [data_width_p-1:0]   old_q;
    logic [data_width_p-1:0]   wdata_q;
    logic                      illegal_q;
    logic                      r_v_q;
    logic                      w_v_q;
    logic                      resp_v_q;

    logic                      kill;
    logic                      req0_ok;
    logic                      pick1;
    logic                      grant_v;
    logic                      do_write;
    logic [data_width_p-1:0]   wdata_d;

    // A flush only ever cancels work owned by the pipe path.
    assign kill    = flush_i & ~owner_q;
    assign req0_ok = req_v_i[0] & ~flush_i;
    assign grant_v = req0_ok | req_v_i[1];

`ifdef BP_BE_CSR_ARB_FAIR_EN
    logic [3:0] starve_q;
    assign pick1 = req_v_i[1] & (~req0_ok | (int'(starve_q) >= starve_limit_p));
`else
    assign pick1 = req_v_i[1] & ~req0_ok;
`endif

    assign do_write = ~csr_illegal_i & ((op_q == 2'b01) | (op_q[1] & (data_q != '0)));

    always_comb begin
        wdata_d = data_q;
        case (op_q)
            2'b10:   wdata_d = csr_data_i | data_q;
            2'b11:   wdata_d = csr_data_i & ~data_q;
            default: wdata_d = data_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            yumi_q    <= '0;
            owner_q   <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
            r_v_q     <= 1'b0;
            w_v_q     <= 1'b0;
            resp_v_q  <= 1'b0;
`ifdef BP_BE_CSR_ARB_FAIR_EN
            starve_q  <= '0;
`endif
        end else begin
            yumi_q <= '0;
            r_v_q  <= 1'b0;
            w_v_q  <= 1'b0;
            case (state_q)
                e_idle: begin
                    if (grant_v) begin
                        state_q <= e_read;
                        yumi_q  <= pick1 ? 2'b10 : 2'b01;
                        owner_q <= pick1;
                        op_q    <= req_op_i[pick1];
                        addr_q  <= req_addr_i[pick1];
                        data_q  <= req_data_i[pick1];
                        r_v_q   <= 1'b1;
                    end
`ifdef BP_BE_CSR_ARB_FAIR_EN
                    if (pick1)
                        starve_q <= '0;
                    else if (req_v_i[1] && starve_q != 4'hF)
                        starve_q <= starve_q + 4'd1;
`endif
                end
                e_read: begin
                    state_q <= kill ? e_idle : e_capture;
                end
                e_capture: begin
                    if (kill) begin
                        state_q <= e_idle;
                    end else begin
                        old_q     <= csr_data_i;
                        illegal_q <= csr_illegal_i;
                        if (do_write) begin
                            wdata_q <= wdata_d;
                            w_v_q   <= 1'b1;
                            state_q <= e_write;
                        end else begin
                            resp_v_q <= 1'b1;
                            state_q  <= e_resp;
                        end
                    end
                end
                e_write: begin
                    if (kill) begin
                        state_q <= e_idle;
                    end else begin
                        resp_v_q <= 1'b1;
                        state_q  <= e_resp;
                    end
                end
                e_resp: begin
                    if (kill || resp_ready_i) begin
                        resp_v_q <= 1'b0;
                        state_q  <= e_idle;
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    // Strobe and response are masked in the flush cycle itself, not just afterwards.
    assign csr_w_v_o      = w_v_q & ~kill;
    assign resp_v_o       = resp_v_q & ~kill;
    assign req_yumi_o     = yumi_q;
    assign csr_r_v_o      = r_v_q;
    assign csr_addr_o     = addr_q;
    assign csr_data_o     = wdata_q;
    assign resp_id_o      = owner_q;
    assign resp_data_o    = old_q;
    assign resp_illegal_o = illegal_q;

endmodule

// File: tb/tb_bp_be_csr_access_arbiter.sv
// tb/tb_bp_be_csr_access_arbiter.sv - scoreboard bench for bp_be_csr_access_arbiter
module tb_bp_be_csr_access_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [1:0]       req_v;
    logic [1:0]       yumi;
    logic [1:0][1:0]  req_op;
    logic [1:0][11:0] req_addr;
    logic [1:0][63:0] req_data;
    logic             resp_v, resp_id, resp_illegal, resp_ready;
    logic [63:0]      resp_data;
    logic             csr_r_v, csr_w_v, csr_illegal;
    logic [11:0]      csr_addr;
    logic [63:0]      csr_wdata, csr_rdata;

    bp_be_csr_access_arbiter dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .req_v_i(req_v), .req_yumi_o(yumi), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_v_o(resp_v), .resp_id_o(resp_id), .resp_data_o(resp_data),
        .resp_illegal_o(resp_illegal), .resp_ready_i(resp_ready),
        .csr_r_v_o(csr_r_v), .csr_w_v_o(csr_w_v), .csr_addr_o(csr_addr),
        .csr_data_o(csr_wdata), .csr_data_i(csr_rdata), .csr_illegal_i(csr_illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; logic [63:0] data; logic ill; int lat; } resp_t;
    typedef struct { logic [11:0] addr; logic [63:0] data; } wr_t;

    resp_t       resp_q[$];
    wr_t         wr_q[$];
    logic [63:0] env_mem[16];
    logic [63:0] ref_mem[16];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          yumi_cyc = 0;
    bit          resp_seen = 0;
    bit          hold_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: RMW semantics on an abstract CSR array, in grant order.
    task automatic expect_txn(input logic id, input logic [1:0] op, input logic [11:0] addr,
                              input logic [63:0] data, input bit with_resp, input bit commit);
        logic [63:0] old = ref_mem[addr[3:0]];
        logic        ill = (addr[3:0] == 4'hF);
        logic        wr  = !ill && (op == 2'b01 || (op >= 2'b10 && data != 64'd0));
        logic [63:0] nv  = (op == 2'b01) ? data : (op == 2'b10) ? (old | data) : (old & ~data);
        if (with_resp) resp_q.push_back('{id, old, ill, wr ? 3 : 2});
        if (wr) begin
            wr_q.push_back('{addr, nv});
            if (commit) ref_mem[addr[3:0]] = nv;
        end
    endtask

    task automatic drive_req(input logic id, input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data);
        req_op[id] = op; req_addr[id] = addr; req_data[id] = data; req_v[id] = 1'b1;
    endtask

    task automatic wait_yumi(input logic id, output int waited);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (yumi[id]) begin req_v[id] = 1'b0; waited = i; return; end
        end
        check("yumi_timeout", yumi[id], 1'b1);
        req_v[id] = 1'b0;
        waited = -1;
    endtask

    task automatic run_txn(input logic id, input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data);
        int w;
        expect_txn(id, op, addr, data, 1, 1);
        drive_req(id, op, addr, data);
        wait_yumi(id, w);
    endtask

    task automatic rand_txn(input logic id);
        logic [1:0]  op  = 2'($urandom_range(0, 3));
        logic [3:0]  idx = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        logic [63:0] d   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
        run_txn(id, op, {8'h34, idx}, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && resp_q.size() != 0; i++) @(negedge clk);
        if (resp_q.size() != 0) check("drain_timeout", resp_v, 1'b0);
        @(negedge clk);
    endtask

    // CSR file environment: read data valid the cycle after the strobe, writes land on the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (csr_r_v) begin
                csr_rdata   = env_mem[csr_addr[3:0]];
                csr_illegal = (csr_addr[3:0] == 4'hF);
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            if (csr_w_v && !reset) env_mem[csr_addr[3:0]] = csr_wdata;
        end
    end

    initial begin : monitor
        resp_t e;
        wr_t   w;
        forever begin
            @(negedge clk);
            resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (!reset) begin
                if (yumi != 2'b00) begin
                    check("yumi_onehot", (yumi == 2'b01 || yumi == 2'b10), 1'b1);
                    yumi_cyc = cyc;
                end
                if (resp_v) begin
                    if (resp_q.size() == 0) check("resp_unexpected", resp_v, 1'b0);
                    else begin
                        e = resp_q[0];
                        check("resp_fields", {resp_id, resp_illegal, resp_data}, {e.id, e.ill, e.data});
                        if (!resp_seen) begin
                            check("resp_latency", cyc - yumi_cyc, e.lat);
                            resp_seen = 1;
                        end
                        if (resp_ready) begin void'(resp_q.pop_front()); resp_seen = 0; end
                    end
                end
                if (csr_w_v) begin
                    if (wr_q.size() == 0) check("write_unexpected", csr_w_v, 1'b0);
                    else begin
                        w = wr_q.pop_front();
                        check("write_fields", {csr_addr, csr_wdata}, {w.addr, w.data});
                    end
                end
            end
        end
    end

    initial begin : stim
        int w;
        bit any;
        logic [63:0] v;
        reset = 1; flush = 0; req_v = '0; req_op = '0; req_addr = '0; req_data = '0;
        csr_rdata = '0; csr_illegal = 0; resp_ready = 0;
        for (int i = 0; i < 16; i++) begin v = {$urandom, $urandom}; env_mem[i] = v; ref_mem[i] = v; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {yumi, resp_v, resp_id, resp_data, resp_illegal, csr_r_v, csr_w_v, csr_addr, csr_wdata}, '0);
        reset = 0;
        @(negedge clk);

        env_mem[0] = 64'h1800; ref_mem[0] = 64'h1800;
        run_txn(1, 2'b10, 12'h300, 64'h8);
        run_txn(0, 2'b11, 12'h305, 64'h0);
        run_txn(0, 2'b01, 12'h30F, 64'hdead);
        drain();

        drive_req(0, 2'b01, 12'h306, 64'h55);
        wait_yumi(0, w);
        flush = 1;
        @(negedge clk);
        flush = 0;
        expect_txn(1, 2'b00, 12'h306, 64'h0, 1, 1);
        drive_req(1, 2'b00, 12'h306, 64'h0);
        wait_yumi(1, w);
        check("grant_after_flush", w, 1);
        drain();

        expect_txn(1, 2'b00, 12'h307, 64'h0, 1, 1);
        expect_txn(0, 2'b10, 12'h307, 64'hF0, 1, 1);
        drive_req(0, 2'b10, 12'h307, 64'hF0);
        drive_req(1, 2'b00, 12'h307, 64'h0);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_idle_grant", yumi, 2'b10);
        req_v[1] = 1'b0;
        wait_yumi(0, w);
        drain();

        hold_low = 1;
        run_txn(0, 2'b00, 12'h308, 64'h0);
        expect_txn(1, 2'b01, 12'h309, 64'h1234, 1, 1);
        drive_req(1, 2'b01, 12'h309, 64'h1234);
        any = 0;
        repeat (8) begin @(negedge clk); if (yumi != 2'b00) any = 1; end
        check("no_yumi_stall", any, 1'b0);
        hold_low = 0;
        wait_yumi(1, w);
        drain();

        drive_req(1, 2'b00, 12'h30A, 64'h0);
`ifdef BP_BE_CSR_ARB_FAIR_EN
        for (int k = 0; k < 8; k++) rand_txn(0);
        expect_txn(1, 2'b00, 12'h30A, 64'h0, 1, 1);
        expect_txn(0, 2'b10, 12'h345, 64'h3, 1, 1);
        drive_req(0, 2'b10, 12'h345, 64'h3);
        wait_yumi(1, w);
        wait_yumi(0, w);
`else
        for (int k = 0; k < 10; k++) rand_txn(0);
        expect_txn(1, 2'b00, 12'h30A, 64'h0, 1, 1);
        wait_yumi(1, w);
`endif
        drain();

        for (int k = 0; k < 60; k++) begin
            rand_txn(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        expect_txn(0, 2'b01, 12'h30B, 64'hABCD, 0, 0);
        drive_req(0, 2'b01, 12'h30B, 64'hABCD);
        wait_yumi(0, w);
        any = 0;
        for (int i = 0; i < 6 && !any; i++) begin @(negedge clk); if (csr_w_v) any = 1; end
        check("write_before_reset", csr_w_v, 1'b1);
        #2 reset = 1;
        #1 check("reset_async", {yumi, resp_v, resp_id, resp_data, resp_illegal, csr_r_v, csr_w_v, csr_addr, csr_wdata}, '0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        run_txn(0, 2'b00, 12'h30B, 64'h0);
        run_txn(1, 2'b11, 12'h30B, 64'hFF);
        drain();

        check("resp_queue_empty", resp_q.size(), 0);
        check("write_queue_empty", wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
